// File: rtl/flags_register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module  : flags_register_file_pkg
// Purpose : Shared helpers for the receive-slot flag bank.
// Revision: 1.0 - initial release
// ============================================================================
package flags_register_file_pkg;

    // Set dominates clear so a fresh arrival is never dropped by a release.
    function automatic logic next_flag(input logic cur, input logic set, input logic clr);
        if (set)
            return 1'b1;
        else if (clr)
            return 1'b0;
        else
            return cur;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flags_register_file_if.sv
`default_nettype none
// ============================================================================
// Module  : flags_register_file_if
// Purpose : Set/clear/poll bus of the receive-slot flag bank.
// Revision: 1.0 - initial release
// ============================================================================
interface flags_register_file_if #(
    parameter int ADDRESS_WIDTH = 1
);
    localparam int NUM_FLAGS = 2 ** ADDRESS_WIDTH;

    logic                     rx_write_enable;
    logic                     rtr_write_enable;
    logic [ADDRESS_WIDTH-1:0] address_1;
    logic [ADDRESS_WIDTH-1:0] address_2;
    logic                     read_data;
    logic [NUM_FLAGS-1:0]     flags;
    logic                     any_flag;

    modport master (
        output rx_write_enable, rtr_write_enable, address_1, address_2,
        input  read_data, flags, any_flag
    );

    modport slave (
        input  rx_write_enable, rtr_write_enable, address_1, address_2,
        output read_data, flags, any_flag
    );
endinterface
`default_nettype wire

// File: rtl/flags_register_file_flag_cell.sv
`default_nettype none
// ============================================================================
// Module  : flag_cell
// Purpose : One status flag with synchronous reset and set-over-clear priority.
// Revision: 1.0 - initial release
// ============================================================================
module flag_cell
    import flags_register_file_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic set_i,
    input  wire logic clear_i,
    output logic      flag_o
);
    logic flag_q;
    logic flag_d;

    always_comb begin
        flag_d = next_flag(flag_q, set_i, clear_i);
    end

    always_ff @(posedge clk) begin
        if (reset)
            flag_q <= 1'b0;
        else
            flag_q <= flag_d;
    end

    assign flag_o = flag_q;
endmodule
`default_nettype wire

// File: rtl/flags_register_file.sv
`default_nettype none
// ============================================================================
// Module  : flags_register_file
// Purpose : Bank of per-slot receive flags: rx sets, rtr clears, core polls.
// Revision: 1.0 - initial release
// ============================================================================
module flags_register_file
    import flags_register_file_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    flags_register_file_if.slave bus
);
    localparam int NUM_FLAGS = 2 ** ADDRESS_WIDTH;

    logic [NUM_FLAGS-1:0] flags_q;
    logic [NUM_FLAGS-1:0] set_d;
    logic [NUM_FLAGS-1:0] clear_d;

    generate
        for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_slot
            assign set_d[i]   = bus.rx_write_enable  && (bus.address_1 == ADDRESS_WIDTH'(i));
            assign clear_d[i] = bus.rtr_write_enable && (bus.address_2 == ADDRESS_WIDTH'(i));

            flag_cell u_cell (
                .clk     (clk),
                .reset   (reset),
                .set_i   (set_d[i]),
                .clear_i (clear_d[i]),
                .flag_o  (flags_q[i])
            );
        end
    endgenerate

    // Read side is purely combinational off the stored bits: no write-through.
    assign bus.read_data = flags_q[bus.address_2];
    assign bus.flags     = flags_q;
    assign bus.any_flag  = |flags_q;
endmodule
`default_nettype wire

// File: tb/tb_flags_register_file.sv
`default_nettype none
// ============================================================================
// Module  : tb_flags_register_file
// Purpose : Self-checking bench for the flag bank at widths 1 and 3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_flags_register_file;

    typedef struct packed {
        logic       rst;
        logic       rxe;
        logic       rte;
        logic       a1;
        logic       a2;
        logic [1:0] ef;
        logic       erd;
        logic       eany;
    } vec_t;

    typedef struct packed {
        logic [1:0] ef;
        logic       erd;
        logic       eany;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic reset3 = 1'b1;
    int   tests = 0;
    int   fails = 0;

    flags_register_file_if #(.ADDRESS_WIDTH(1)) bus1 ();
    flags_register_file_if #(.ADDRESS_WIDTH(3)) bus3 ();

    flags_register_file #(.ADDRESS_WIDTH(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    flags_register_file #(.ADDRESS_WIDTH(3)) u_dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive3(input logic r, input logic rxe, input logic [2:0] a1,
                          input logic rte, input logic [2:0] a2);
        reset3                = r;
        bus3.rx_write_enable  = rxe;
        bus3.address_1        = a1;
        bus3.rtr_write_enable = rte;
        bus3.address_2        = a2;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [18];
    exp_t sb [$];

    initial begin
        exp_t e;

        bus1.rx_write_enable  = 1'b0;
        bus1.rtr_write_enable = 1'b0;
        bus1.address_1        = 1'b0;
        bus1.address_2        = 1'b0;
        bus3.rx_write_enable  = 1'b0;
        bus3.rtr_write_enable = 1'b0;
        bus3.address_1        = 3'd0;
        bus3.address_2        = 3'd0;

        //          rst   rxe   rte   a1    a2    flags  rd    any
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1};

        for (int i = 0; i < 18; i++) begin
            reset                 = vecs[i].rst;
            bus1.rx_write_enable  = vecs[i].rxe;
            bus1.rtr_write_enable = vecs[i].rte;
            bus1.address_1        = vecs[i].a1;
            bus1.address_2        = vecs[i].a2;
            sb.push_back('{vecs[i].ef, vecs[i].erd, vecs[i].eany});
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_flags", i), 32'(bus1.flags),     32'(e.ef));
                chk($sformatf("v%0d_rd", i),    32'(bus1.read_data), 32'(e.erd));
                chk($sformatf("v%0d_any", i),   32'(bus1.any_flag),  32'(e.eany));
            end
        end

        // Pending set must not show before its edge, then show right after it.
        bus1.rx_write_enable  = 1'b1;
        bus1.rtr_write_enable = 1'b0;
        bus1.address_1        = 1'b0;
        bus1.address_2        = 1'b0;
        #1;
        chk("no_write_through_rd",    32'(bus1.read_data), 32'd0);
        chk("no_write_through_flags", 32'(bus1.flags),     32'h2);
        @(posedge clk);
        #1;
        chk("set_visible_after_edge", 32'(bus1.read_data), 32'd1);
        bus1.rx_write_enable = 1'b0;
        bus1.address_2       = 1'b1;
        #1;
        chk("rd_follows_addr",        32'(bus1.read_data), 32'd1);

        // Width-3 bank.
        drive3(1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        chk("w3_reset_flags", 32'(bus3.flags), 32'h00);
        drive3(1'b0, 1'b1, 3'd0, 1'b0, 3'd0);
        drive3(1'b0, 1'b1, 3'd5, 1'b0, 3'd0);
        drive3(1'b0, 1'b1, 3'd7, 1'b0, 3'd0);
        chk("w3_set_flags", 32'(bus3.flags), 32'hA1);
        drive3(1'b0, 1'b0, 3'd0, 1'b1, 3'd5);
        chk("w3_clear_flags", 32'(bus3.flags),     32'h81);
        chk("w3_rd5",         32'(bus3.read_data), 32'd0);
        drive3(1'b0, 1'b0, 3'd0, 1'b0, 3'd7);
        chk("w3_rd7",         32'(bus3.read_data), 32'd1);
        chk("w3_any",         32'(bus3.any_flag),  32'd1);
        drive3(1'b0, 1'b1, 3'd3, 1'b1, 3'd0);
        chk("w3_simul_flags", 32'(bus3.flags), 32'h88);
        drive3(1'b0, 1'b1, 3'd6, 1'b1, 3'd6);
        chk("w3_same_addr",   32'(bus3.flags), 32'hC8);
        drive3(1'b1, 1'b1, 3'd2, 1'b0, 3'd0);
        chk("w3_reset_mid",   32'(bus3.flags),    32'h00);
        chk("w3_reset_any",   32'(bus3.any_flag), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
